// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared processor definitions used by the instruction fetch
//               stage (FSM encoding, default bubble instruction).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding-request instruction fetch stage with
//               hold buffer for pipeline freezes and redirect draining.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid,
    output logic        fetch_stall
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_buffer;
    logic [31:0]  r_tgt;

    logic [31:0]  w_pc_inc;
    logic [31:0]  w_branch_tgt;

    assign w_pc_inc     = r_pc + 32'd4;
    assign w_branch_tgt = word_align(branch_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_REQ;
            r_pc     <= word_align(RESET_PC);
            r_buffer <= 32'h0000_0000;
            r_tgt    <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (branch_taken) begin
                        if (mem_ready) begin
                            r_pc <= w_branch_tgt;
                        end else begin
                            // Request must stay up at the old address until it completes.
                            r_tgt   <= w_branch_tgt;
                            r_state <= ST_DRAIN;
                        end
                    end else if (mem_ready) begin
                        if (freeze) begin
                            r_buffer <= mem_rdata;
                            r_state  <= ST_HOLD;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        r_pc    <= w_branch_tgt;
                        r_state <= ST_REQ;
                    end else if (!freeze) begin
                        r_pc    <= w_pc_inc;
                        r_state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) begin
                        r_tgt <= w_branch_tgt;
                        if (mem_ready) begin
                            r_pc    <= w_branch_tgt;
                            r_state <= ST_REQ;
                        end
                    end else if (mem_ready) begin
                        r_pc    <= r_tgt;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b1;
        valid       = 1'b0;
        instruction = NOP_INSTR;
        case (r_state)
            ST_REQ: begin
                valid = mem_ready & ~branch_taken;
                if (valid) begin
                    instruction = mem_rdata;
                end
            end
            ST_HOLD: begin
                mem_req = 1'b0;
                valid   = ~branch_taken;
                if (valid) begin
                    instruction = r_buffer;
                end
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    assign mem_addr    = r_pc;
    assign pc_out      = w_pc_inc;
    assign fetch_stall = mem_req & ~mem_ready;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit using a per-cycle
//               expected-output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_GARBAGE  = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;
    logic        fetch_stall;

    typedef struct packed {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] ba;
        logic        rdy;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pco;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .NOP_INSTR (c_NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .valid        (valid),
        .fetch_stall  (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the word address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata = mem_ready ? mw(mem_addr) : c_GARBAGE;

    function automatic stim_t S(input logic r, input logic f, input logic b,
                                input logic [31:0] a, input logic y);
        return '{rst: r, frz: f, br: b, ba: a, rdy: y};
    endfunction

    function automatic exp_t E(input logic q, input logic [31:0] a, input logic v,
                               input logic [31:0] i, input logic [31:0] p, input logic s);
        return '{req: q, addr: a, vld: v, ins: i, pco: p, stall: s};
    endfunction

    function automatic exp_t observe();
        return '{req: mem_req, addr: mem_addr, vld: valid, ins: instruction,
                 pco: pc_out, stall: fetch_stall};
    endfunction

    task automatic apply(input stim_t st, input exp_t ex);
        @(negedge clk);
        rst          = st.rst;
        freeze       = st.frz;
        branch_taken = st.br;
        branch_addr  = st.ba;
        mem_ready    = st.rdy;
        sb.push_back(ex);
        #1;
    endtask

    task automatic test_reset();
        exp_t got, ex;
        for (int i = 0; i < 2; i++) begin
            apply(S(1, 0, 0, 32'h0, 0), E(1, c_RESET_PC, 0, c_NOP, c_RESET_PC + 4, 1));
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, got, ex);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 0, 0, 1)); ex.push_back(E(1, 32'h0, 1, mw(32'h0), 32'h4, 0));
        st.push_back(S(0, 0, 0, 0, 1)); ex.push_back(E(1, 32'h4, 1, mw(32'h4), 32'h8, 0));
        st.push_back(S(0, 0, 0, 0, 1)); ex.push_back(E(1, 32'h8, 1, mw(32'h8), 32'hC, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL sequential[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_freeze_hold();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 1, 32'h10, 1)); ex.push_back(E(1, 32'hC,  0, c_NOP, 32'h10, 0));
        st.push_back(S(0, 1, 0, 0, 1));      ex.push_back(E(1, 32'h10, 1, mw(32'h10), 32'h14, 0));
        st.push_back(S(0, 1, 0, 0, 0));      ex.push_back(E(0, 32'h10, 1, mw(32'h10), 32'h14, 0));
        st.push_back(S(0, 1, 0, 0, 0));      ex.push_back(E(0, 32'h10, 1, mw(32'h10), 32'h14, 0));
        st.push_back(S(0, 0, 0, 0, 0));      ex.push_back(E(0, 32'h10, 1, mw(32'h10), 32'h14, 0));
        st.push_back(S(0, 0, 0, 0, 0));      ex.push_back(E(1, 32'h14, 0, c_NOP, 32'h18, 1));
        st.push_back(S(0, 0, 0, 0, 1));      ex.push_back(E(1, 32'h14, 1, mw(32'h14), 32'h18, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL freeze_hold[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_drain_redirect();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 1, 32'h20, 1));  ex.push_back(E(1, 32'h18,  0, c_NOP, 32'h1C, 0));
        st.push_back(S(0, 0, 1, 32'h100, 0)); ex.push_back(E(1, 32'h20,  0, c_NOP, 32'h24, 1));
        st.push_back(S(0, 0, 0, 0, 0));       ex.push_back(E(1, 32'h20,  0, c_NOP, 32'h24, 1));
        st.push_back(S(0, 0, 0, 0, 1));       ex.push_back(E(1, 32'h20,  0, c_NOP, 32'h24, 0));
        st.push_back(S(0, 0, 0, 0, 0));       ex.push_back(E(1, 32'h100, 0, c_NOP, 32'h104, 1));
        st.push_back(S(0, 0, 0, 0, 1));       ex.push_back(E(1, 32'h100, 1, mw(32'h100), 32'h104, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL drain_redirect[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_hold_branch();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 1, 0, 0, 1));       ex.push_back(E(1, 32'h104, 1, mw(32'h104), 32'h108, 0));
        st.push_back(S(0, 1, 1, 32'h203, 0)); ex.push_back(E(0, 32'h104, 0, c_NOP, 32'h108, 0));
        st.push_back(S(0, 0, 0, 0, 0));       ex.push_back(E(1, 32'h200, 0, c_NOP, 32'h204, 1));
        st.push_back(S(0, 0, 0, 0, 1));       ex.push_back(E(1, 32'h200, 1, mw(32'h200), 32'h204, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL hold_branch[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 1, 32'hFFFF_FFFE, 1));
        ex.push_back(E(1, 32'h204, 0, c_NOP, 32'h208, 0));
        st.push_back(S(0, 0, 0, 0, 1));
        ex.push_back(E(1, 32'hFFFF_FFFC, 1, mw(32'hFFFF_FFFC), 32'h0, 0));
        st.push_back(S(0, 0, 0, 0, 0));
        ex.push_back(E(1, 32'h0, 0, c_NOP, 32'h4, 1));
        st.push_back(S(0, 0, 0, 0, 1));
        ex.push_back(E(1, 32'h0, 1, mw(32'h0), 32'h4, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 1, 32'h40, 0)); ex.push_back(E(1, 32'h4,  0, c_NOP, 32'h8, 1));
        st.push_back(S(0, 1, 1, 32'h80, 0)); ex.push_back(E(1, 32'h4,  0, c_NOP, 32'h8, 1));
        st.push_back(S(0, 0, 0, 0, 0));      ex.push_back(E(1, 32'h4,  0, c_NOP, 32'h8, 1));
        st.push_back(S(0, 1, 0, 0, 1));      ex.push_back(E(1, 32'h4,  0, c_NOP, 32'h8, 0));
        st.push_back(S(0, 0, 1, 32'h90, 0)); ex.push_back(E(1, 32'h80, 0, c_NOP, 32'h84, 1));
        st.push_back(S(0, 0, 1, 32'hA0, 1)); ex.push_back(E(1, 32'h80, 0, c_NOP, 32'h84, 0));
        st.push_back(S(0, 0, 0, 0, 1));      ex.push_back(E(1, 32'hA0, 1, mw(32'hA0), 32'hA4, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_transaction();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        // Reset while draining towards 0x80: the redirect must be forgotten.
        st.push_back(S(0, 0, 1, 32'h80, 0)); ex.push_back(E(1, 32'hA4, 0, c_NOP, 32'hA8, 1));
        st.push_back(S(1, 0, 0, 0, 0));      ex.push_back(E(1, c_RESET_PC, 0, c_NOP, c_RESET_PC + 4, 1));
        st.push_back(S(0, 0, 0, 0, 1));      ex.push_back(E(1, 32'h0, 1, mw(32'h0), 32'h4, 0));
        st.push_back(S(0, 0, 0, 0, 0));      ex.push_back(E(1, 32'h4, 0, c_NOP, 32'h8, 1));
        // Reset while holding a buffered word: the word must not reappear.
        st.push_back(S(0, 1, 0, 0, 1));      ex.push_back(E(1, 32'h4, 1, mw(32'h4), 32'h8, 0));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(E(1, c_RESET_PC, 0, c_NOP, c_RESET_PC + 4, 1));
        st.push_back(S(0, 1, 0, 0, 0));      ex.push_back(E(1, c_RESET_PC, 0, c_NOP, c_RESET_PC + 4, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        mem_ready    = 1'b0;

        test_reset();
        test_sequential();
        test_freeze_hold();
        test_drain_redirect();
        test_hold_branch();
        test_wrap();
        test_back_to_back();
        test_reset_mid_transaction();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_residue got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
